// File: rtl/msw_pkg.sv
// Shared constants and types for the Minesweeper board streamer.
// Board size defaults, frame header, cell glyph codes and FSM states.
package msw_pkg;

  localparam int DEF_BOARD_W = 8;
  localparam int DEF_BOARD_H = 8;

  localparam logic [7:0] HDR_BYTE        = 8'hA5;
  localparam logic [7:0] GLYPH_HIDDEN    = 8'h0B;
  localparam logic [7:0] GLYPH_FLAG      = 8'h0A;
  localparam logic [7:0] GLYPH_MINE_HIT  = 8'h09;
  localparam logic [7:0] GLYPH_MINE_SHOW = 8'h0C;
  localparam logic [7:0] GLYPH_BAD_FLAG  = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_STAT,
    S_CELL,
    S_CSUM
  } state_t;

endpackage

// File: rtl/msw_cell_encode.sv
// Combinational cell glyph encoder: idx + snapshot vectors + game_over
// -> glyph byte (neighbour-mine count with board-edge clipping).
module msw_cell_encode
  import msw_pkg::*;
#(
  parameter int BOARD_W    = DEF_BOARD_W,
  parameter int BOARD_H    = DEF_BOARD_H,
  parameter int BOARD_SIZE = BOARD_W * BOARD_H,
  parameter int IDX_W      = $clog2(BOARD_SIZE)
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic [BOARD_SIZE-1:0] revealed,
  input  logic [BOARD_SIZE-1:0] flagged,
  input  logic [BOARD_SIZE-1:0] mines,
  input  logic                  game_over,
  output logic [7:0]            glyph
);

  logic [3:0]       cnt;
  logic [IDX_W-1:0] ni;
  int               x;
  int               y;
  int               nx;
  int               ny;

  always_comb begin
    cnt = '0;
    ni  = '0;
    nx  = 0;
    ny  = 0;
    x   = int'(idx) % BOARD_W;
    y   = int'(idx) / BOARD_W;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = x + dx;
        ny = y + dy;
        if (!(dx == 0 && dy == 0) &&
            nx >= 0 && nx < BOARD_W &&
            ny >= 0 && ny < BOARD_H) begin
          ni  = IDX_W'(ny * BOARD_W + nx);
          cnt = cnt + 4'(mines[ni]);
        end
      end
    end
  end

  // First match wins, so this stays a priority chain.
  always_comb begin
    if (revealed[idx] && mines[idx])
      glyph = GLYPH_MINE_HIT;
    else if (revealed[idx])
      glyph = {4'b0, cnt};
    else if (flagged[idx] && game_over && !mines[idx])
      glyph = GLYPH_BAD_FLAG;
    else if (flagged[idx])
      glyph = GLYPH_FLAG;
    else if (game_over && mines[idx])
      glyph = GLYPH_MINE_SHOW;
    else
      glyph = GLYPH_HIDDEN;
  end

endmodule

// File: rtl/minesweeper_board_streamer.sv
// Snapshots the core's board vectors and streams them as a byte frame
// (A5, status, 64 cell glyphs[, checksum]) over valid/ready.
// Ports: clk, reset (async high), snap_req, revealed/flagged/mines,
// game_over, win in; busy, out_valid, out_data, out_last, frame_done
// out; out_ready in. Optional checksum byte: MSW_STREAM_CSUM_EN.
module minesweeper_board_streamer
  import msw_pkg::*;
#(
  parameter int BOARD_W    = DEF_BOARD_W,
  parameter int BOARD_H    = DEF_BOARD_H,
  parameter int BOARD_SIZE = BOARD_W * BOARD_H
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  snap_req,
  input  logic [BOARD_SIZE-1:0] revealed,
  input  logic [BOARD_SIZE-1:0] flagged,
  input  logic [BOARD_SIZE-1:0] mines,
  input  logic                  game_over,
  input  logic                  win,
  output logic                  busy,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(BOARD_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOARD_SIZE - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      enc_idx;
  logic [BOARD_SIZE-1:0] snap_rev;
  logic [BOARD_SIZE-1:0] snap_flag;
  logic [BOARD_SIZE-1:0] snap_mine;
  logic                  snap_go;
  logic                  snap_win;
  logic [7:0]            glyph;
  logic [7:0]            status_byte;
  logic                  accept;

  assign accept      = out_valid && out_ready;
  assign busy        = (state != S_IDLE);
  assign status_byte = {6'b0, snap_win, snap_go};

  // idx is the cell on the bus; the encoder looks one cell ahead so
  // the next glyph is ready at acceptance. In STAT it prepares cell 0.
  assign enc_idx = (state == S_CELL) ? idx + ONE : '0;

  msw_cell_encode #(
    .BOARD_W    (BOARD_W),
    .BOARD_H    (BOARD_H),
    .BOARD_SIZE (BOARD_SIZE),
    .IDX_W      (IDX_W)
  ) u_enc (
    .idx       (enc_idx),
    .revealed  (snap_rev),
    .flagged   (snap_flag),
    .mines     (snap_mine),
    .game_over (snap_go),
    .glyph     (glyph)
  );

`ifdef MSW_STREAM_CSUM_EN
  logic [7:0] csum;
  logic       load_stat;
  logic       load_cell;

  assign load_stat = accept && (state == S_HDR);
  assign load_cell = accept &&
                     ((state == S_STAT) ||
                      (state == S_CELL && idx != LAST_IDX));

  // Running sum of every byte loaded after the header.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      csum <= '0;
    else if (load_stat)
      csum <= status_byte;
    else if (load_cell)
      csum <= csum + glyph;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      snap_rev   <= '0;
      snap_flag  <= '0;
      snap_mine  <= '0;
      snap_go    <= 1'b0;
      snap_win   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (snap_req) begin
            snap_rev  <= revealed;
            snap_flag <= flagged;
            snap_mine <= mines;
            snap_go   <= game_over;
            snap_win  <= win;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= HDR_BYTE;
            out_last  <= 1'b0;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept) begin
            out_data <= status_byte;
            state    <= S_STAT;
          end
        end
        S_STAT: begin
          if (accept) begin
            out_data <= glyph;
            state    <= S_CELL;
          end
        end
        S_CELL: begin
          if (accept) begin
            idx <= idx + ONE;
            if (idx == LAST_IDX) begin
`ifdef MSW_STREAM_CSUM_EN
              out_data <= csum;
              out_last <= 1'b1;
              state    <= S_CSUM;
`else
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
`endif
            end else begin
              out_data <= glyph;
`ifdef MSW_STREAM_CSUM_EN
              out_last <= 1'b0;
`else
              out_last <= (idx + ONE == LAST_IDX);
`endif
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minesweeper_board_streamer.sv
// Self-checking bench for minesweeper_board_streamer: random boards
// against a coordinate-based frame model, stalls, back-to-back, reset.
module tb_minesweeper_board_streamer;

`ifdef MSW_STREAM_CSUM_EN
  localparam int FLEN = 67;
  localparam bit CSUM = 1'b1;
`else
  localparam int FLEN = 66;
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        snap_req;
  logic [63:0] revealed;
  logic [63:0] flagged;
  logic [63:0] mines;
  logic        game_over;
  logic        win;
  logic        busy;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        frame_done;

  always #5 clk = ~clk;

  minesweeper_board_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .snap_req   (snap_req),
    .revealed   (revealed),
    .flagged    (flagged),
    .mines      (mines),
    .game_over  (game_over),
    .win        (win),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] m_rev, m_flag, m_mine;
  logic        m_go, m_win;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          last_cnt, last_pos, stall_bad, first_cyc, last_cyc;
  bit          done_ok, timed_out;
  int          fd_cnt = 0;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

  function automatic logic [7:0] ref_glyph(int x, int y);
    int n = 0;
    int i = y * 8 + x;
    for (int yy = y - 1; yy <= y + 1; yy++)
      for (int xx = x - 1; xx <= x + 1; xx++)
        if (xx >= 0 && xx < 8 && yy >= 0 && yy < 8 &&
            !(xx == x && yy == y) && m_mine[yy*8+xx])
          n++;
    if (m_rev[i] && m_mine[i]) return 8'h09;
    if (m_rev[i]) return 8'(n);
    if (m_flag[i] && m_go && !m_mine[i]) return 8'h0D;
    if (m_flag[i]) return 8'h0A;
    if (m_go && m_mine[i]) return 8'h0C;
    return 8'h0B;
  endfunction

  task automatic build_expected();
    int sum;
    logic [7:0] g;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back({6'b0, m_win, m_go});
    sum = {m_win, m_go};
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        g = ref_glyph(x, y);
        exp_q.push_back(g);
        sum += g;
      end
    if (CSUM) exp_q.push_back(8'(sum));
  endtask

  task automatic start_snap(input bit wait_first,
                            input logic [63:0] r, f, m,
                            input logic go, w);
    if (wait_first) @(negedge clk);
    revealed = r; flagged = f; mines = m;
    game_over = go; win = w;
    m_rev = r; m_flag = f; m_mine = m; m_go = go; m_win = w;
    build_expected();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1-0-1..., 2: random ready
  task automatic collect(input int mode, input int max_cycles);
    logic       prev_stall;
    logic [7:0] pd;
    logic       pl;
    bit         r;
    prev_stall = 1'b0; pd = '0; pl = 1'b0;
    got_q.delete();
    last_cnt = 0; last_pos = -1; stall_bad = 0;
    done_ok = 1'b0; timed_out = 1'b1;
    first_cyc = -1; last_cyc = -1;
    for (int c = 0; c < max_cycles; c++) begin
      if (prev_stall &&
          (out_valid !== 1'b1 || out_data !== pd || out_last !== pl))
        stall_bad++;
      case (mode)
        0:       r = 1'b1;
        1:       r = (c % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = c;
        prev_stall = !r; pd = out_data; pl = out_last;
        if (r) begin
          got_q.push_back(out_data);
          last_cyc = c;
          if (out_last === 1'b1) begin
            last_cnt++;
            last_pos = got_q.size();
            @(negedge clk);
            done_ok = (frame_done === 1'b1) && (busy === 1'b0);
            timed_out = 1'b0;
            out_ready = 1'b0;
            break;
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; snap_req = 1'b0; out_ready = 1'b0;
    revealed = '0; flagged = '0; mines = '0; game_over = 0; win = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %02h want 00", out_data); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", out_last); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset valid %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_all_hidden();
    start_snap(1, '0, '0, '0, 1'b0, 1'b0);
    collect(0, 200);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL hidden_timeout got %0d bytes want %0d", got_q.size(), FLEN); end
    n_chk++; if (got_q.size() !== FLEN) begin n_fail++; $display("FAIL hidden_len got %0d want %0d", got_q.size(), FLEN); end
    for (int i = 0; i < FLEN && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hidden_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (got_q.size() > 0 && got_q[got_q.size()-1] !== (CSUM ? 8'hC0 : 8'h0B)) begin
      n_fail++; $display("FAIL hidden_final got %02h want %02h", got_q[got_q.size()-1], CSUM ? 8'hC0 : 8'h0B); end
    n_chk++; if (last_pos !== FLEN || last_cnt !== 1) begin
      n_fail++; $display("FAIL hidden_last pos %0d cnt %0d want %0d 1", last_pos, last_cnt, FLEN); end
    n_chk++; if (!done_ok) begin n_fail++; $display("FAIL hidden_done got 0 want 1"); end
    n_chk++; if (first_cyc !== 0 || last_cyc !== FLEN - 1) begin
      n_fail++; $display("FAIL hidden_timing first %0d last %0d want 0 %0d", first_cyc, last_cyc, FLEN - 1); end
  endtask

  task automatic test_neighbours();
    start_snap(1, 64'hFFFF_FFFF_FFFF_FFFE, '0, 64'h1, 1'b0, 1'b1);
    collect(0, 200);
    n_chk++; if (got_q.size() !== FLEN) begin n_fail++; $display("FAIL nb_len got %0d want %0d", got_q.size(), FLEN); end
    n_chk++; if (got_q[1] !== 8'h02) begin n_fail++; $display("FAIL nb_status got %02h want 02", got_q[1]); end
    n_chk++; if (got_q[3] !== 8'h01) begin n_fail++; $display("FAIL nb_cell1 got %02h want 01", got_q[3]); end
    n_chk++; if (got_q[10] !== 8'h01) begin n_fail++; $display("FAIL nb_cell8 got %02h want 01", got_q[10]); end
    n_chk++; if (got_q[11] !== 8'h01) begin n_fail++; $display("FAIL nb_cell9 got %02h want 01", got_q[11]); end
    n_chk++; if (got_q[65] !== 8'h00) begin n_fail++; $display("FAIL nb_cell63 got %02h want 00", got_q[65]); end
    for (int i = 0; i < FLEN && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nb_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_glyphs();
    start_snap(1, 64'h1, 64'hA0, 64'h21, 1'b1, 1'b0);
    collect(0, 200);
    n_chk++; if (got_q.size() !== FLEN) begin n_fail++; $display("FAIL gl_len got %0d want %0d", got_q.size(), FLEN); end
    n_chk++; if (got_q[1] !== 8'h01) begin n_fail++; $display("FAIL gl_status got %02h want 01", got_q[1]); end
    n_chk++; if (got_q[2] !== 8'h09) begin n_fail++; $display("FAIL gl_cell0 got %02h want 09", got_q[2]); end
    n_chk++; if (got_q[3] !== 8'h0B) begin n_fail++; $display("FAIL gl_cell1 got %02h want 0B", got_q[3]); end
    n_chk++; if (got_q[7] !== 8'h0A) begin n_fail++; $display("FAIL gl_cell5 got %02h want 0A", got_q[7]); end
    n_chk++; if (got_q[9] !== 8'h0D) begin n_fail++; $display("FAIL gl_cell7 got %02h want 0D", got_q[9]); end
    for (int i = 0; i < FLEN && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gl_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall_random();
    for (int k = 0; k < 5; k++) begin
      start_snap(1, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom} & {$urandom, $urandom},
                 1'($urandom), 1'($urandom));
      // inputs move after the snapshot; the frame must not follow them
      revealed = {$urandom, $urandom}; mines = {$urandom, $urandom};
      flagged = ~flagged; game_over = ~game_over; win = ~win;
      collect(k == 0 ? 1 : 2, 1000);
      n_chk++; if (timed_out) begin n_fail++; $display("FAIL st%0d_timeout got %0d bytes", k, got_q.size()); end
      n_chk++; if (got_q.size() !== FLEN) begin n_fail++; $display("FAIL st%0d_len got %0d want %0d", k, got_q.size(), FLEN); end
      n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL st%0d_stable got %0d unstable stalls want 0", k, stall_bad); end
      n_chk++; if (last_pos !== FLEN || !done_ok) begin
        n_fail++; $display("FAIL st%0d_last pos %0d done %b want %0d 1", k, last_pos, done_ok, FLEN); end
      for (int i = 0; i < FLEN && i < got_q.size(); i++) begin
        n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL st%0d_byte[%0d] got %02h want %02h", k, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    start_snap(1, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom} & {$urandom, $urandom}, 1'b0, 1'b1);
    collect(0, 200);
    n_chk++; if (!done_ok) begin n_fail++; $display("FAIL b2b_done1 got 0 want 1"); end
    // request lands in the frame_done cycle
    start_snap(0, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom} & {$urandom, $urandom}, 1'b1, 1'b0);
    collect(0, 200);
    n_chk++; if (first_cyc !== 0 || got_q.size() !== FLEN) begin
      n_fail++; $display("FAIL b2b_start first %0d len %0d want 0 %0d", first_cyc, got_q.size(), FLEN); end
    for (int i = 0; i < FLEN && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_busy_reset();
    logic [63:0] br, bf, bm;
    br = {$urandom, $urandom}; bf = {$urandom, $urandom};
    bm = {$urandom, $urandom} & {$urandom, $urandom};
    start_snap(1, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom} & {$urandom, $urandom}, 1'b0, 1'b0);
    fd_cnt = 0;
    got_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      got_q.push_back(out_data);
      if (c == 10) begin
        revealed = br; flagged = bf; mines = bm; game_over = 1'b1;
        snap_req = 1'b1;
      end
      if (c == 11) snap_req = 1'b0;
      if (c < 32) @(negedge clk);
    end
    for (int i = 0; i <= 32; i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL br_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    reset = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
                 out_last !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL br_reset busy %b valid %b data %02h last %b done %b want 0 0 00 0 0",
                         busy, out_valid, out_data, out_last, frame_done); end
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL br_no_queue valid %b busy %b want 0 0", out_valid, busy); end
    n_chk++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL br_no_done got %0d pulses want 0", fd_cnt); end
    start_snap(1, br, bf, bm, 1'b1, 1'b1);
    collect(0, 200);
    n_chk++; if (got_q.size() !== FLEN || !done_ok) begin
      n_fail++; $display("FAIL br_refresh len %0d done %b want %0d 1", got_q.size(), done_ok, FLEN); end
    for (int i = 0; i < FLEN && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL br2_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_all_hidden();
    test_neighbours();
    test_glyphs();
    test_stall_random();
    test_back_to_back();
    test_busy_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/minesweeper_board_streamer.md
# minesweeper_board_streamer

Reads the 8×8 game-state vectors published by the Minesweeper core and serialises them into a byte-stream frame for the host link. It snapshots revealed/flagged/mines/status on request, encodes each cell as a display glyph (including its neighbour-mine count), and emits the frame over a valid/ready handshake. It sits between the core's state outputs and the host transport, so the host never samples the 64-bit vectors directly.

## Interface
- BOARD_W, 8, board width in cells
- BOARD_H, 8, board height in cells
- BOARD_SIZE, BOARD_W*BOARD_H (64), cells per frame; vectors are BOARD_SIZE wide
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- snap_req  in  1  frame request; sampled only in IDLE
- revealed  in  64  core revealed vector, bit y*BOARD_W+x
- flagged  in  64  core flagged vector
- mines  in  64  core mine vector
- game_over  in  1  core loss status
- win  in  1  core win status
- busy  out  1  frame in progress (any state but IDLE)
- out_valid  out  1  out_data valid
- out_data  out  8  stream byte
- out_last  out  1  final byte of frame
- out_ready  in  1  sink accepts byte
- frame_done  out  1  one-cycle pulse after final byte accepted

## Operation
- Frame: 0xA5 header, status byte {6'b0, win, game_over}, 64 cell bytes row-major (y outer, x inner), then checksum byte if enabled.
- Snapshot: on snap_req in IDLE, all four inputs copied into internal registers; the frame reflects that snapshot only.
- Cell glyph, first match wins: revealed&mine → 0x09; revealed → neighbour-mine count 0x00–0x08 (8-neighbourhood, off-board ignored); flagged&game_over&!mine → 0x0D (wrong flag); flagged → 0x0A; game_over&mine → 0x0C (exposed mine); else → 0x0B (hidden).
- FSM: IDLE → HDR (snap_req) → STAT → CELL (64 bytes, 6-bit index 0..63) → CSUM (if enabled) → IDLE. Each state advances only on out_valid&out_ready.
- CELL leaves when index 63 is accepted; index wraps to 0 and is not re-used.
- snap_req while busy: ignored, not queued.
- Reset mid-frame: immediate return to IDLE, frame abandoned, no frame_done.

## Timing
- Reset values: busy 0, out_valid 0, out_data 0x00, out_last 0, frame_done 0; snapshot registers 0; index 0.
- snap_req sampled at edge N → out_valid=1 with 0xA5 from N+1.
- One byte per cycle with out_ready held high: 66 bytes (67 with checksum), header to last byte in 66/67 consecutive cycles.
- out_data/out_last held stable while out_valid&!out_ready; out_valid never drops before acceptance.
- out_last high only with the final byte. frame_done pulses the cycle after its acceptance; busy falls that same cycle; a snap_req that cycle starts a new frame (next header one cycle later).
- Cell bytes registered: glyph for index i+1 computed while byte i is presented; no bubbles.

## Configuration
- MSW_STREAM_CSUM_EN defined: CSUM state appends one byte = 8-bit modulo-256 sum of status byte and all 64 cell bytes (header excluded); out_last moves to it; frame 67 bytes.
- Undefined: no CSUM state; out_last on cell 63; frame 66 bytes.

## Structure
- Shared package msw_pkg: BOARD_W/BOARD_H defaults, header constant 0xA5, glyph constants (HIDDEN 0x0B, FLAG 0x0A, MINE_HIT 0x09, MINE_SHOW 0x0C, BAD_FLAG 0x0D), FSM state enum.
- One sub-module: msw_cell_encode — combinational; index + snapshot vectors + game_over → glyph byte, including neighbour count with edge clipping.

## Test plan
- Reset, all vectors 0, snap_req, out_ready=1 → A5, 00, 64×0x0B, out_last on byte 66, frame_done next cycle.
- mines bit 0 only, revealed = all except bit 0, win=1 → status 0x02; cell1=01, cell8=01, cell9=01, cell63=00.
- game_over=1, mines bits 0 and 5, revealed bit 0, flagged bits 5 and 7 → cell0=09, cell5=0A, cell7=0D, other hidden=0B.
- out_ready toggled 1-0-1 per cycle → out_data/out_last stable during stalls, 66 accepted bytes in order.
- snap_req during CELL, then reset asserted at cell 30 → request ignored, outputs return to reset values, no frame_done, next snap_req yields full frame.
- With MSW_STREAM_CSUM_EN, all-hidden board → checksum byte 0xC0 (64×0x0B mod 256), out_last on byte 67.
